fetch_queue: RTL

Instruction fetch front end for the pipelined core. Owns the fetch PC, issues word-addressed requests to instruction memory, and buffers in-order responses in a small queue. It presents one instruction per cycle with its PC to the IF/ID pipeline register, honours the decode-stage stall, and redirects on taken branches and jumps resolved in Execute.

---
 rtl/fetch_queue_pkg.sv | 14 +
 rtl/fetch_queue_fifo.sv | 58 +++++
 rtl/fetch_queue.sv | 108 ++++++++++
 3 files changed

// File: rtl/fetch_queue_pkg.sv
// Shared types for the instruction fetch front end (fetch_queue / fetch_fifo).
// Optional same-cycle response bypass is enabled by defining FETCH_BYPASS_EN.
package fetch_queue_pkg;

  localparam int FETCH_DEPTH = 4;

  typedef logic [31:0] word_t;

  typedef struct packed {
    word_t pc;
    word_t instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_queue_fifo.sv
// Synchronous FIFO of fetch entries; flush beats push/pop, pop on empty and push on full are ignored.
// Head is shown combinationally; a write is visible the cycle after the push.
module fetch_fifo
  import fetch_queue_pkg::*;
#(
  parameter int DEPTH = FETCH_DEPTH
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         i_push,
  input  fetch_entry_t                 i_push_dat,
  input  logic                         i_pop,
  input  logic                         i_flush,
  output fetch_entry_t                 o_head,
  output logic                         o_full,
  output logic                         o_empty,
  output logic [$clog2(DEPTH+1)-1:0]   o_count
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int AW = $clog2(DEPTH);

  fetch_entry_t   r_mem [DEPTH];
  logic [AW-1:0]  r_rd;
  logic [AW-1:0]  r_wr;
  logic [CW-1:0]  r_cnt;
  logic           w_push;
  logic           w_pop;

  assign o_empty = (r_cnt == '0);
  assign o_full  = (r_cnt == CW'(DEPTH));
  assign o_count = r_cnt;
  assign o_head  = r_mem[r_rd];
  assign w_pop   = i_pop && !o_empty;
  assign w_push  = i_push && (!o_full || w_pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd  <= '0;
      r_wr  <= '0;
      r_cnt <= '0;
    end else if (i_flush) begin
      r_rd  <= '0;
      r_wr  <= '0;
      r_cnt <= '0;
    end else begin
      if (w_push) r_wr <= r_wr + AW'(1);
      if (w_pop)  r_rd <= r_rd + AW'(1);
      r_cnt <= r_cnt + CW'(w_push) - CW'(w_pop);
    end
  end

  // Storage needs no reset: the count gates every read.
  always_ff @(posedge clk) begin
    if (w_push && !i_flush) r_mem[r_wr] <= i_push_dat;
  end

endmodule

// File: rtl/fetch_queue.sv
// Fetch PC, request issue, in-order response tracking and redirect squashing in front of fetch_fifo.
// Define FETCH_BYPASS_EN to let a response reach instr_out in its arrival cycle when the queue is empty.
module fetch_queue
  import fetch_queue_pkg::*;
#(
  parameter int              XLEN     = 32,
  parameter int              DEPTH    = FETCH_DEPTH,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            reset,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_rsp_valid,
  input  logic [XLEN-1:0] imem_rsp_data,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  input  logic            stall,
  output logic            instr_valid,
  output logic [XLEN-1:0] instr_out,
  output logic [XLEN-1:0] pc_out,
  output logic [XLEN-1:0] pcplus4_out
);

  localparam int            CW    = $clog2(DEPTH + 1);
  localparam logic [CW:0]   LIMIT = (CW + 1)'(DEPTH);

  logic [XLEN-1:0] r_fetch_pc;
  logic [XLEN-1:0] r_rsp_pc;
  logic [CW-1:0]   r_inflight;
  logic [CW-1:0]   r_discard;
  logic [CW-1:0]   w_occ;
  logic [CW:0]     w_used;
  logic            w_fire;
  logic            w_rsp;
  logic            w_rsp_keep;
  logic            w_byp;
  logic            w_push;
  logic            w_pop;
  logic            w_empty;
  logic            w_full;
  fetch_entry_t    w_head;
  fetch_entry_t    w_rsp_entry;
  fetch_entry_t    w_out;

  // Queued entries plus outstanding requests bound the issue window.
  assign w_used         = {1'b0, w_occ} + {1'b0, r_inflight};
  assign imem_req_valid = reset && !redirect_valid && (w_used < LIMIT);
  assign imem_req_addr  = reset ? r_fetch_pc : '0;
  assign w_fire         = imem_req_valid && imem_req_ready;

  assign w_rsp       = imem_rsp_valid && (r_inflight != '0);
  assign w_rsp_keep  = w_rsp && (r_discard == '0) && !redirect_valid;
  assign w_rsp_entry = '{pc: r_rsp_pc, instr: imem_rsp_data};

`ifdef FETCH_BYPASS_EN
  assign w_byp = w_rsp_keep && w_empty;
`else
  assign w_byp = 1'b0;
`endif

  assign instr_valid = !redirect_valid && (!w_empty || w_byp);
  assign w_out       = w_byp ? w_rsp_entry : w_head;
  assign instr_out   = instr_valid ? w_out.instr : '0;
  assign pc_out      = instr_valid ? w_out.pc : '0;
  assign pcplus4_out = instr_valid ? w_out.pc + word_t'(1) : '0;

  assign w_pop  = instr_valid && !stall && !w_byp;
  assign w_push = w_rsp_keep && !(w_byp && !stall) && (!w_full || w_pop);

  fetch_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk        (clk),
    .rst_n      (reset),
    .i_push     (w_push),
    .i_push_dat (w_rsp_entry),
    .i_pop      (w_pop),
    .i_flush    (redirect_valid),
    .o_head     (w_head),
    .o_full     (w_full),
    .o_empty    (w_empty),
    .o_count    (w_occ)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_fetch_pc <= RESET_PC;
      r_rsp_pc   <= RESET_PC;
      r_inflight <= '0;
      r_discard  <= '0;
    end else begin
      r_inflight <= r_inflight + CW'(w_fire) - CW'(w_rsp);
      if (redirect_valid) begin
        r_fetch_pc <= redirect_pc;
        r_rsp_pc   <= redirect_pc;
        // A response landing with the redirect is already squashed here.
        r_discard  <= r_inflight - CW'(w_rsp);
      end else begin
        if (w_fire)          r_fetch_pc <= r_fetch_pc + XLEN'(1);
        if (w_rsp_keep)      r_rsp_pc   <= r_rsp_pc + XLEN'(1);
        else if (w_rsp)      r_discard  <= r_discard - CW'(1);
      end
    end
  end

endmodule
